// File: rtl/axis_mux_pkg.sv
// axis_mux_pkg: shared state encoding, beat layout and arbitration helper
// for the packet-aware 2:1 AXI-Stream mux.
package axis_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS0 = 2'd1,
    PASS1 = 2'd2
  } mux_state_t;

  // Default data width and the sideband bits appended to every beat.
  localparam int unsigned MUX_DATA_W  = 32;
  localparam int unsigned BEAT_META_W = 2;

  // Beat layout at the default width; the mux packs the flat slice word in
  // the same field order {tdata, tlast, tid}.
  typedef struct packed {
    logic [MUX_DATA_W-1:0] tdata;
    logic                  tlast;
    logic                  tid;
  } beat_t;

  // Packet-level arbitration: a lone requester wins; on a tie the input that
  // did not send the previous packet wins.
  function automatic mux_state_t next_grant(input logic s0_valid,
                                            input logic s1_valid,
                                            input logic rr_last);
    mux_state_t grant;
    grant = IDLE;
    if (s0_valid && s1_valid) begin
      grant = rr_last ? PASS0 : PASS1;
    end else if (s0_valid) begin
      grant = PASS0;
    end else if (s1_valid) begin
      grant = PASS1;
    end
    return grant;
  endfunction

endpackage

// File: rtl/axis_skid_slice.sv
// axis_skid_slice: 2-entry registered pipeline slice (main + skid).
// The output is always driven from the main entry; the skid entry catches the
// one beat that may arrive in the cycle the downstream stalls. Input ready is
// taken straight from the skid occupancy flop, so no combinational path runs
// from i_ready to o_ready.
module axis_skid_slice #(
  parameter int unsigned BeatW = 34
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [BeatW-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [BeatW-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic             r_main_valid;
  logic             r_skid_valid;
  logic [BeatW-1:0] r_main_data;
  logic [BeatW-1:0] r_skid_data;
  logic             w_push;
  logic             w_pop;

  assign o_ready = ~r_skid_valid;
  assign o_valid = r_main_valid;
  assign o_data  = r_main_data;
  assign w_push  = i_valid & ~r_skid_valid;
  assign w_pop   = r_main_valid & i_ready;

  // Entry occupancy and data movement: skid refills main on a pop, new beats
  // land in main when it is free (or being emptied) and in skid otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main_data  <= '0;
      r_skid_data  <= '0;
    end else if (w_pop) begin
      if (r_skid_valid) begin
        r_main_data  <= r_skid_data;
        r_skid_valid <= 1'b0;
      end else if (w_push) begin
        r_main_data  <= i_data;
      end else begin
        r_main_valid <= 1'b0;
      end
    end else if (w_push) begin
      if (r_main_valid) begin
        r_skid_data  <= i_data;
        r_skid_valid <= 1'b1;
      end else begin
        r_main_data  <= i_data;
        r_main_valid <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_pkt_mux.sv
// axis_pkt_mux: packet-atomic round-robin 2:1 AXI-Stream mux with a
// registered skid slice on the output and a source-ID sideband (m_tid).
// Optional feature macro: AXIS_MUX_STATS_EN adds per-input completed-packet
// counters pkt_cnt0/pkt_cnt1 (width PktCntWidth, wrapping).
module axis_pkt_mux
  import axis_mux_pkg::*;
#(
  parameter int unsigned DataWidth = MUX_DATA_W
`ifdef AXIS_MUX_STATS_EN
  ,
  parameter int unsigned PktCntWidth = 16
`endif
) (
  input  logic                 counter_clk,
  input  logic                 reset_n,
  input  logic [DataWidth-1:0] s0_tdata,
  input  logic                 s0_tvalid,
  input  logic                 s0_tlast,
  output logic                 s0_tready,
  input  logic [DataWidth-1:0] s1_tdata,
  input  logic                 s1_tvalid,
  input  logic                 s1_tlast,
  output logic                 s1_tready,
  output logic [DataWidth-1:0] m_tdata,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  output logic                 m_tid,
  input  logic                 m_tready
`ifdef AXIS_MUX_STATS_EN
  ,
  output logic [PktCntWidth-1:0] pkt_cnt0,
  output logic [PktCntWidth-1:0] pkt_cnt1
`endif
);

  localparam int unsigned BeatW = DataWidth + BEAT_META_W;

  mux_state_t       r_state;
  mux_state_t       w_state_next;
  logic             r_rr_last;
  logic             w_rr_last_next;
  logic             w_slice_ready;
  logic             w_wr_valid;
  logic [BeatW-1:0] w_wr_beat;
  logic [BeatW-1:0] w_rd_beat;
  logic             w_rd_valid;

  // State register and round-robin pointer; input 0 wins the first tie.
  always_ff @(posedge counter_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_rr_last <= 1'b1;
    end else begin
      r_state   <= w_state_next;
      r_rr_last <= w_rr_last_next;
    end
  end

  // Grant decode, input readies and end-of-packet release back to IDLE.
  always_comb begin
    w_state_next   = r_state;
    w_rr_last_next = r_rr_last;
    s0_tready      = 1'b0;
    s1_tready      = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_state_next = next_grant(s0_tvalid, s1_tvalid, r_rr_last);
      end
      PASS0: begin
        s0_tready = w_slice_ready;
        if (s0_tvalid && w_slice_ready && s0_tlast) begin
          w_state_next   = IDLE;
          w_rr_last_next = 1'b0;
        end
      end
      PASS1: begin
        s1_tready = w_slice_ready;
        if (s1_tvalid && w_slice_ready && s1_tlast) begin
          w_state_next   = IDLE;
          w_rr_last_next = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Route the granted input into the slice, tagged with its source index.
  always_comb begin
    w_wr_valid = 1'b0;
    w_wr_beat  = '0;
    unique case (r_state)
      PASS0: begin
        w_wr_valid = s0_tvalid;
        w_wr_beat  = {s0_tdata, s0_tlast, 1'b0};
      end
      PASS1: begin
        w_wr_valid = s1_tvalid;
        w_wr_beat  = {s1_tdata, s1_tlast, 1'b1};
      end
      default: begin
        w_wr_valid = 1'b0;
      end
    endcase
  end

  axis_skid_slice #(
    .BeatW (BeatW)
  ) u_out_slice (
    .i_clk   (counter_clk),
    .i_rst_n (reset_n),
    .i_data  (w_wr_beat),
    .i_valid (w_wr_valid),
    .o_ready (w_slice_ready),
    .o_data  (w_rd_beat),
    .o_valid (w_rd_valid),
    .i_ready (m_tready)
  );

  assign m_tvalid = w_rd_valid;
  assign m_tdata  = w_rd_beat[BeatW-1:BEAT_META_W];
  assign m_tlast  = w_rd_beat[1];
  assign m_tid    = w_rd_beat[0];

`ifdef AXIS_MUX_STATS_EN
  logic [PktCntWidth-1:0] r_pkt_cnt0;
  logic [PktCntWidth-1:0] r_pkt_cnt1;
  logic                   w_pkt_done;

  assign w_pkt_done = m_tvalid & m_tready & m_tlast;

  // Count packets as their final beat leaves the mux, per source.
  always_ff @(posedge counter_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pkt_cnt0 <= '0;
      r_pkt_cnt1 <= '0;
    end else if (w_pkt_done) begin
      if (m_tid) begin
        r_pkt_cnt1 <= r_pkt_cnt1 + PktCntWidth'(1);
      end else begin
        r_pkt_cnt0 <= r_pkt_cnt0 + PktCntWidth'(1);
      end
    end
  end

  assign pkt_cnt0 = r_pkt_cnt0;
  assign pkt_cnt1 = r_pkt_cnt1;
`endif

endmodule

// File: tb/tb_axis_pkt_mux.sv
// tb_axis_pkt_mux: scoreboard bench. Drivers push each packet's beats into a
// per-source expected queue; a monitor pops on every output handshake and
// checks data, tlast, source, packet atomicity and hold-while-stalled.
`timescale 1ns/1ps
module tb_axis_pkt_mux;

  localparam int DW = 32;
`ifdef AXIS_MUX_STATS_EN
  localparam int PCW = 2;
`endif

  logic          counter_clk = 1'b0;
  logic          reset_n     = 1'b0;
  logic [DW-1:0] s0_tdata    = '0;
  logic          s0_tvalid   = 1'b0;
  logic          s0_tlast    = 1'b0;
  logic          s0_tready;
  logic [DW-1:0] s1_tdata    = '0;
  logic          s1_tvalid   = 1'b0;
  logic          s1_tlast    = 1'b0;
  logic          s1_tready;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tid;
  logic          m_tready    = 1'b1;
`ifdef AXIS_MUX_STATS_EN
  logic [PCW-1:0] pkt_cnt0;
  logic [PCW-1:0] pkt_cnt1;
`endif

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model state
  logic [32:0] exp0[$];
  logic [32:0] exp1[$];
  int          pkt_order[$];
  int          gaps[$];
  int          rdy_mode = 0;
  bit          in_pkt = 0;
  bit          lock_tid = 0;
  bit          have_end = 0;
  int          last_end_cyc = 0;
  bit          prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic        prev_last;
  logic        prev_tid;

  int s1_beats = 0;
  bit s1_done  = 0;
  int viol     = 0;

  axis_pkt_mux #(
    .DataWidth (DW)
`ifdef AXIS_MUX_STATS_EN
    ,
    .PktCntWidth (PCW)
`endif
  ) dut (
    .counter_clk (counter_clk),
    .reset_n     (reset_n),
    .s0_tdata    (s0_tdata),
    .s0_tvalid   (s0_tvalid),
    .s0_tlast    (s0_tlast),
    .s0_tready   (s0_tready),
    .s1_tdata    (s1_tdata),
    .s1_tvalid   (s1_tvalid),
    .s1_tlast    (s1_tlast),
    .s1_tready   (s1_tready),
    .m_tdata     (m_tdata),
    .m_tvalid    (m_tvalid),
    .m_tlast     (m_tlast),
    .m_tid       (m_tid),
    .m_tready    (m_tready)
`ifdef AXIS_MUX_STATS_EN
    ,
    .pkt_cnt0    (pkt_cnt0),
    .pkt_cnt1    (pkt_cnt1)
`endif
  );

  always #5 counter_clk = ~counter_clk;
  always @(posedge counter_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic flush_model();
    exp0.delete();
    exp1.delete();
    pkt_order.delete();
    gaps.delete();
    in_pkt     = 0;
    have_end   = 0;
    prev_stall = 0;
  endtask

  // Present one beat from the current negedge and hold it until accepted.
  task automatic drive_beat(input int src, input logic [31:0] d, input logic l);
    int n;
    n = 0;
    if (src == 0) begin s0_tdata = d; s0_tlast = l; s0_tvalid = 1'b1; end
    else          begin s1_tdata = d; s1_tlast = l; s1_tvalid = 1'b1; end
    while (!((src == 0) ? s0_tready : s1_tready) && n < 500) begin
      @(negedge counter_clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL drv_timeout src=%0d actual=no_ready required=ready", src);
    end
    @(negedge counter_clk);
    if (src == 0) s0_tvalid = 1'b0;
    else          s1_tvalid = 1'b0;
  endtask

  task automatic send_pkt(input int src, input int len, input logic [31:0] base,
                          input int step, input int max_gap);
    logic [31:0] d;
    logic        l;
    for (int i = 0; i < len; i++) begin
      d = base + 32'(step * i);
      l = (i == len - 1);
      if (src == 0) exp0.push_back({l, d});
      else          exp1.push_back({l, d});
    end
    for (int i = 0; i < len; i++) begin
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) @(negedge counter_clk);
      drive_beat(src, base + 32'(step * i), (i == len - 1));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp0.size() != 0 || exp1.size() != 0 || m_tvalid) && n < 1000) begin
      @(negedge counter_clk);
      n++;
    end
    chk("drain_exp0_empty", exp0.size(), 0);
    chk("drain_exp1_empty", exp1.size(), 0);
  endtask

  task automatic apply_reset();
    @(negedge counter_clk);
    #2 reset_n = 1'b0;
    s0_tvalid = 1'b0;
    s1_tvalid = 1'b0;
    flush_model();
    repeat (2) @(negedge counter_clk);
    #2 reset_n = 1'b1;
    @(negedge counter_clk);
  endtask

  // Monitor: owns m_tready, checks every output handshake against the queues.
  initial begin : monitor
    logic        rdy;
    logic [32:0] e;
    forever begin
      @(negedge counter_clk);
      if (prev_stall && reset_n) begin
        chk("hold_tvalid", m_tvalid, 1);
        chk("hold_tdata", m_tdata, prev_data);
        chk("hold_tlast", m_tlast, prev_last);
        chk("hold_tid", m_tid, prev_tid);
      end
      case (rdy_mode)
        1:       rdy = ~m_tready;
        2:       rdy = ($urandom_range(0, 3) != 0);
        default: rdy = 1'b1;
      endcase
      m_tready = rdy;
      if (m_tvalid && rdy && reset_n) begin
        if (!in_pkt) begin
          pkt_order.push_back(int'(m_tid));
          if (have_end) gaps.push_back(cyc - last_end_cyc);
          in_pkt   = 1;
          lock_tid = m_tid;
        end else begin
          chk("pkt_atomic_tid", m_tid, lock_tid);
        end
        checks++;
        if ((m_tid ? exp1.size() : exp0.size()) == 0) begin
          failures++;
          $display("FAIL unexpected_beat tid=%0d actual=%0h required=none", m_tid, m_tdata);
        end else begin
          e = m_tid ? exp1.pop_front() : exp0.pop_front();
          chk("beat_data", m_tdata, e[31:0]);
          chk("beat_last", m_tlast, e[32]);
        end
        if (m_tlast) begin
          in_pkt       = 0;
          have_end     = 1;
          last_end_cyc = cyc;
        end
      end
      prev_stall = m_tvalid && !rdy && reset_n;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
      prev_tid   = m_tid;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "simulation timeout");
  end

  initial begin : stimulus
    int k0;
    int n;

    // Reset values
    reset_n = 1'b0;
    repeat (3) @(negedge counter_clk);
    chk("rst_m_tvalid", m_tvalid, 0);
    chk("rst_m_tdata", m_tdata, 0);
    chk("rst_m_tlast", m_tlast, 0);
    chk("rst_m_tid", m_tid, 0);
    chk("rst_s0_tready", s0_tready, 0);
    chk("rst_s1_tready", s1_tready, 0);
`ifdef AXIS_MUX_STATS_EN
    chk("rst_pkt_cnt0", pkt_cnt0, 0);
    chk("rst_pkt_cnt1", pkt_cnt1, 0);
`endif
    #2 reset_n = 1'b1;
    @(negedge counter_clk);
    $display("T1 s0 3-beat packet 5,6,7");

    // Single 3-beat packet and grant+data latency
    fork
      send_pkt(0, 3, 32'd5, 1, 0);
      begin
        k0 = cyc;
        n  = 0;
        while (!m_tvalid && n < 50) begin
          @(negedge counter_clk);
          n++;
        end
        chk("first_mvalid_latency", cyc - k0, 2);
      end
    join
    drain();

    // Round robin, both inputs valid straight out of reset
    apply_reset();
    $display("T2 round robin s0/s1 two 2-beat packets each");
    fork
      begin send_pkt(0, 2, 32'h10, 1, 0); send_pkt(0, 2, 32'h20, 1, 0); end
      begin send_pkt(1, 2, 32'h30, 1, 0); send_pkt(1, 2, 32'h40, 1, 0); end
    join
    drain();
    chk("rr_pkt_count", pkt_order.size(), 4);
    for (int i = 0; i < pkt_order.size() && i < 4; i++)
      chk($sformatf("rr_order_%0d", i), pkt_order[i], i % 2);
    chk("gap_count", gaps.size(), 3);
    for (int i = 0; i < gaps.size(); i++)
      chk($sformatf("pkt_gap_%0d", i), gaps[i], 2);

    // s1 packet is not interrupted by s0 arriving mid-packet
    $display("T3 s1 4-beat FFFFFFFF..FFFFFFFC with s0 contending");
    s1_beats = 0;
    s1_done  = 0;
    viol     = 0;
    fork
      send_pkt(1, 4, 32'hFFFF_FFFF, -1, 0);
      begin
        n = 0;
        while (s1_beats < 1 && n < 100) begin
          @(negedge counter_clk);
          n++;
        end
        send_pkt(0, 2, 32'h55, 1, 0);
      end
      begin
        for (int i = 0; i < 60 && !s1_done; i++) begin
          @(negedge counter_clk);
          if (s0_tready) viol++;
          if (s1_tvalid && s1_tready) begin
            s1_beats++;
            if (s1_tlast) s1_done = 1;
          end
        end
      end
    join
    drain();
    chk("s0_blocked_during_s1", viol, 0);
    chk("s1_pkt_completed", s1_done, 1);

    // Output backpressure toggling every cycle
    $display("T4 s0 8-beat packet with m_tready toggling");
    rdy_mode = 1;
    send_pkt(0, 8, 32'd0, 1, 0);
    drain();
    rdy_mode = 0;
    @(negedge counter_clk);

    // Reset mid-packet, then a fresh s1 packet
    $display("T5 reset after 2 of 4 beats, then s1 packet");
    exp0.push_back({1'b0, 32'hA0});
    exp0.push_back({1'b0, 32'hA1});
    drive_beat(0, 32'hA0, 1'b0);
    drive_beat(0, 32'hA1, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_s0_tready", s0_tready, 0);
    chk("midrst_s1_tready", s1_tready, 0);
    flush_model();
    repeat (2) @(negedge counter_clk);
    #2 reset_n = 1'b1;
    @(negedge counter_clk);
    send_pkt(1, 3, 32'h100, 3, 0);
    drain();

`ifdef AXIS_MUX_STATS_EN
    // Counter wrap with a 2-bit counter
    apply_reset();
    $display("T6 five single-beat s0 packets, counter wrap");
    for (int i = 0; i < 5; i++) send_pkt(0, 1, 32'(i + 1), 1, 1);
    drain();
    chk("pkt_cnt0_wrap", pkt_cnt0, 1);
    chk("pkt_cnt1_zero", pkt_cnt1, 0);
`endif

    // Randomized traffic on both inputs with random backpressure
    $display("T7 randomized traffic");
    rdy_mode = 2;
    fork
      begin
        for (int p = 0; p < 10; p++) begin
          repeat ($urandom_range(0, 3)) @(negedge counter_clk);
          send_pkt(0, $urandom_range(1, 5), $urandom, $urandom_range(1, 9), 2);
        end
      end
      begin
        for (int p = 0; p < 10; p++) begin
          repeat ($urandom_range(0, 3)) @(negedge counter_clk);
          send_pkt(1, $urandom_range(1, 5), $urandom, $urandom_range(1, 9), 2);
        end
      end
    join
    drain();
    rdy_mode = 0;
    repeat (2) @(negedge counter_clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axis_pkt_mux.md
# axis_pkt_mux

Packet-aware 2:1 AXI-Stream multiplexer sitting directly downstream of the up/down counter streamers: input 0 takes the up-counter stream, input 1 the down-counter stream. Whole packets (delimited by tlast) are forwarded atomically with round-robin arbitration between packets. A registered output slice with skid storage decouples output backpressure from the inputs. A source-ID sideband tags each beat with the input it came from.

## Interface
- DataWidth, 32, tdata width of both inputs and the output
- PktCntWidth, 16, width of per-input packet counters (only with AXIS_MUX_STATS_EN)

- counter_clk  in  1  single clock; all logic on rising edge
- reset_n  in  1  asynchronous assert, active-low; synchronous deassert is provided externally
- s0_tdata  in  DataWidth  input 0 data
- s0_tvalid  in  1  input 0 valid
- s0_tlast  in  1  input 0 end of packet
- s0_tready  out  1  input 0 ready
- s1_tdata / s1_tvalid / s1_tlast / s1_tready  same as input 0, for input 1
- m_tdata  out  DataWidth  output data
- m_tvalid  out  1  output valid
- m_tlast  out  1  output end of packet
- m_tid  out  1  source input of the current output beat (0 or 1)
- m_tready  in  1  output ready
- pkt_cnt0, pkt_cnt1  out  PktCntWidth  completed packets forwarded per input (stats only)

## Operation
- FSM states: IDLE, PASS0, PASS1. Reset state IDLE; priority pointer rr_last = 1, so input 0 wins the first tie.
- IDLE: both s*_tready = 0. If exactly one s*_tvalid is high, go to the matching PASS state next cycle. If both are high, grant the input not equal to rr_last. If neither, stay.
- PASSn: sn_tready = slice_ready; the other input's tready = 0. Each sn handshake (tvalid & tready) writes {tdata, tlast, n} into the output slice.
- When a handshake in PASSn carries tlast = 1: rr_last <= n, next state IDLE.
- A packet is never interrupted; the ungranted input waits regardless of how long the granted packet stalls.
- A single-beat packet (tlast on its first beat) is legal: PASSn lasts one handshake and the FSM returns to IDLE.
- Output slice: 2 entries (main + skid). slice_ready is registered and is 1 whenever the skid entry is empty. m_* is driven from the main entry. On an m handshake the skid entry moves into main, if occupied.
- tdata, tlast and tid are passed unmodified; there is no width conversion.

## Timing
- Reset values: m_tvalid 0, m_tdata 0, m_tlast 0, m_tid 0, s0_tready 0, s1_tready 0, pkt_cnt* 0, state IDLE.
- Reset asserted mid-packet clears the FSM, both slice entries and the counters immediately. Partial packets are dropped, not completed.
- Grant latency: tvalid seen in IDLE at cycle N, so tready = 1 at cycle N+1 and the first handshake can occur at N+1.
- Data latency: an s handshake at cycle N gives m_tvalid with that beat at N+1.
- With m_tready held at 1, throughput inside a packet is 1 beat per cycle. There is exactly one bubble cycle (IDLE) between consecutive packets.
- m_tready low: at most one further input beat is absorbed into the skid entry. s*_tready falls in the cycle after the skid fills. No beat is lost or duplicated.
- m_tvalid, once high, stays high with m_tdata, m_tlast and m_tid stable until the m handshake.

## Configuration
- AXIS_MUX_STATS_EN defined: pkt_cnt0/pkt_cnt1 ports exist. Each counter increments by 1 on every m handshake with m_tlast = 1 and m_tid equal to its input. The counters wrap modulo 2^PktCntWidth.
- Not defined: these ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package axis_mux_pkg: state enum (IDLE, PASS0, PASS1) and a beat struct {tdata, tlast, tid}.
- Sub-module axis_skid_slice: 2-entry registered slice, parameterised on beat width. It is instantiated once, on the output.

## Test plan
- Reset, then 3-beat packet on s0 (data 5,6,7, tlast on 7), m_tready = 1. Required: m shows 5,6,7 with m_tid = 0; first m_tvalid 2 cycles after s0_tvalid; tlast only on 7.
- s0 and s1 both valid from reset, each sending two 2-beat packets. Required output packet order: s0, s1, s0, s1, with one idle cycle between packets.
- s1 sends a 4-beat packet (FFFFFFFF..FFFFFFFC) while s0 raises tvalid at the second beat. Required: s0_tready stays 0 until the s1 beat with tlast is accepted; the s1 packet is contiguous on m.
- m_tready toggled 1/0 every cycle during an 8-beat s0 packet (0..7). Required: all 8 beats appear once, in order, with no data change while m_tvalid = 1 and m_tready = 0.
- reset_n pulsed low mid-packet after 2 of 4 beats. Required: m_tvalid = 0 and s*_tready = 0 asynchronously; after release, a fresh s1 packet is forwarded correctly.
- With AXIS_MUX_STATS_EN and PktCntWidth = 2: 5 single-beat packets on s0. Required: pkt_cnt0 = 1 (wrapped); pkt_cnt1 = 0.
